// File: rtl/delay_cfg_sequencer_pkg.sv
// Shared types and constants for the delay configuration sequencer:
// FSM states, word field positions and parameter defaults.
package delay_cfg_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    SEND,
    WAIT_ACK,
    WAIT_IDLE,
    DONE
  } state_t;

  localparam logic [31:0] HEADER_DFLT      = 32'h02002000;
  localparam int          ACK_TIMEOUT_DFLT = 16;

  localparam int NUM_PORTS = 4;
  localparam int ID_MSB    = 31;
  localparam int ID_LSB    = 28;
  localparam int PORT_MSB  = 27;
  localparam int PORT_LSB  = 24;
  localparam int DLY_MSB   = 23;
  localparam int DLY_LSB   = 0;

  localparam logic [2:0] SENT_MAX = 3'd4;

endpackage

// File: rtl/delay_cfg_word_pack.sv
// Builds one 64-bit UART configuration word: header, AWG id, port index, delay.
module delay_cfg_word_pack
  import delay_cfg_sequencer_pkg::*;
#(
  parameter logic [31:0] HEADER = HEADER_DFLT
) (
  input  logic [3:0]  i_awg_id,
  input  logic [1:0]  i_port_idx,
  input  logic [23:0] i_delay,
  output logic [63:0] o_word
);

  always_comb begin
    o_word                    = '0;
    o_word[63:32]             = HEADER;
    o_word[ID_MSB:ID_LSB]     = i_awg_id;
    o_word[PORT_MSB:PORT_LSB] = {2'b00, i_port_idx};
    o_word[DLY_MSB:DLY_LSB]   = i_delay;
  end

endmodule

// File: rtl/delay_cfg_sequencer.sv
// Sends one batch of per-port delay words to a UART TX, lowest port first,
// with a handshake on I_tx_ready and an ACK timeout that aborts the batch.
module delay_cfg_sequencer
  import delay_cfg_sequencer_pkg::*;
#(
  parameter logic [31:0] HEADER      = HEADER_DFLT,
  parameter int          ACK_TIMEOUT = ACK_TIMEOUT_DFLT
) (
  input  logic        I_clk_10M,
  input  logic        I_rst,
  input  logic        I_start,
  input  logic [3:0]  I_awg_id,
  input  logic [3:0]  I_port_mask,
  input  logic [23:0] I_delay0,
  input  logic [23:0] I_delay1,
  input  logic [23:0] I_delay2,
  input  logic [23:0] I_delay3,
  input  logic        I_tx_ready,
  output logic [63:0] O_data,
  output logic        O_data_valid,
  output logic        O_busy,
  output logic        O_done,
  output logic        O_error,
  output logic [2:0]  O_sent_cnt
);

  localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);

  state_t                r_state;
  logic [3:0]            r_awg_id;
  logic [3:0][23:0]      r_delay;
  logic [3:0]            r_mask;
  logic [3:0]            r_sent;
  logic [TMR_W-1:0]      r_timer;
  logic [63:0]           r_data;
  logic                  r_valid;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_error;
  logic [2:0]            r_sent_cnt;

  logic                  w_accept;
  logic [3:0]            w_pending;
  logic                  w_any;
  logic [1:0]            w_idx;
  logic [63:0]           w_word;

  assign w_accept  = (r_state == IDLE) && I_start && !I_rst;
  assign w_pending = r_mask & ~r_sent;

  // Descending scan so the lowest pending index wins.
  always_comb begin
    w_any = 1'b0;
    w_idx = 2'd0;
    for (int p = NUM_PORTS - 1; p >= 0; p--) begin
      if (w_pending[p]) begin
        w_any = 1'b1;
        w_idx = 2'(p);
      end
    end
  end

  delay_cfg_word_pack #(
    .HEADER (HEADER)
  ) u_word_pack (
    .i_awg_id   (r_awg_id),
    .i_port_idx (w_idx),
    .i_delay    (r_delay[w_idx]),
    .o_word     (w_word)
  );

  // Batch payload is captured only when a start is accepted; no reset needed.
  always_ff @(posedge I_clk_10M) begin
    if (w_accept) begin
      r_awg_id <= I_awg_id;
      r_delay  <= {I_delay3, I_delay2, I_delay1, I_delay0};
    end
  end

  always_ff @(posedge I_clk_10M) begin
    if (I_rst) begin
      r_state    <= IDLE;
      r_mask     <= '0;
      r_sent     <= '0;
      r_timer    <= '0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_sent_cnt <= '0;
    end else begin
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (I_start) begin
            r_mask     <= I_port_mask;
            r_sent     <= '0;
            r_error    <= 1'b0;
            r_sent_cnt <= '0;
            r_busy     <= 1'b1;
            r_state    <= SELECT;
          end
        end
        SELECT: begin
          if (w_any) begin
            r_data        <= w_word;
            r_sent[w_idx] <= 1'b1;
            r_state       <= SEND;
          end else begin
            r_state <= DONE;
          end
        end
        SEND: begin
          if (I_tx_ready) begin
            r_valid <= 1'b1;
            r_timer <= '0;
            r_state <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (!I_tx_ready) begin
            r_state <= WAIT_IDLE;
          end else if (r_timer == TMR_W'(ACK_TIMEOUT)) begin
            r_error <= 1'b1;
            r_state <= DONE;
          end else begin
            r_timer <= r_timer + TMR_W'(1);
          end
        end
        WAIT_IDLE: begin
          if (I_tx_ready) begin
            if (r_sent_cnt < SENT_MAX) r_sent_cnt <= r_sent_cnt + 3'd1;
            r_state <= SELECT;
          end
        end
        DONE: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign O_data       = r_data;
  assign O_data_valid = r_valid;
  assign O_busy       = r_busy;
  assign O_done       = r_done;
  assign O_error      = r_error;
  assign O_sent_cnt   = r_sent_cnt;

endmodule
